icache_2way: RTL and testbench
==============================

# icache_2way

Parametrised two-way set-associative instruction cache with LRU replacement, variable-latency refill handshake and whole-cache flush. Sits between the CPU instruction-fetch port and the instruction memory bus, in place of a direct-mapped I-cache. A hit returns the word with one-cycle registered latency. A miss stalls the CPU until the memory acknowledges a full line.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width
- INDEX_WIDTH, 8, set index bits (2**INDEX_WIDTH sets)
- WORD_BITS, 2, word-in-line bits (LINE_WORDS = 2**WORD_BITS, line = 32*LINE_WORDS bits)
- Derived TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - WORD_BITS - 2

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- cs  in  1  fetch request valid (active high)
- addr  in  ADDR_WIDTH  fetch byte address; CPU holds it stable while cache_stall_n=0
- flush  in  1  one-cycle pulse, invalidate all lines
- dout  out  32  fetched instruction (registered)
- cache_stall_n  out  1  0 = CPU must stall
- iaddr  out  ADDR_WIDTH  line-aligned refill address
- ireq  out  1  refill request
- iack  in  1  refill data valid on data_in this cycle
- data_in  in  32*LINE_WORDS  refill line, word 0 in the most significant 32 bits
- hit_cnt, miss_cnt  out  32  only when ICACHE_STATS_EN is defined

## Operation
- Address split: word = addr[WORD_BITS+1:2], index = next INDEX_WIDTH bits, tag = remaining upper bits.
- Per set: valid[2], tag[2], line[2], one lru bit naming the least recently used way.
- hit = cs and (valid[w] and tag[w]==tag) for some way w, combinational. At most one way hits; a dual hit is a design error.
- FSM states:
  - LOOKUP (reset state):
    - cs & hit: dout <= selected word; lru <= ~w.
    - cs & ~hit: go to REFILL.
    - cs=0: nothing changes; dout holds.
  - REFILL: ireq=1, iaddr = {addr[ADDR_WIDTH-1:WORD_BITS+2], zeros}. On iack: write data_in, tag and valid=1 into the victim way, set lru <= ~victim, go to LOOKUP. The following lookup then hits.
- Victim selection: way 0 if invalid, else way 1 if invalid, else the way named by lru.
- cache_stall_n = ~((state==LOOKUP & cs & ~hit) | state==REFILL), combinational.
- ireq = (state==REFILL), so it is registered-state driven.
- flush: at the edge, clears all valid bits and all lru bits, in any state.
  - In REFILL without iack, the refill continues and completes normally.
  - Flush coincident with iack: the line and tag are written but valid stays 0, and the FSM returns to LOOKUP (re-miss follows).
  - Flush coincident with a LOOKUP hit: dout is still updated for that hit.
- Reset mid-REFILL: state goes to LOOKUP and ireq drops immediately (async). Nothing is written. A late iack arriving in LOOKUP is ignored.

## Timing
- Reset values: dout=0, cache_stall_n=1 (with cs=0), ireq=0, iaddr=line address of addr, all valid=0, lru=0, counters=0.
- Hit: addr/cs at cycle N, dout valid after edge N+1, no stall.
- Miss with memory acknowledging k cycles after ireq rises (k>=0):
  - Stall cycles: 1 (LOOKUP miss) + k + 1 (iack cycle). Then 1 hit cycle, so dout is updated k+3 edges after the miss cycle.
- iack is only sampled in REFILL. data_in must be valid in the iack cycle.
- iaddr is combinational from addr, which is held stable during the stall.

## Configuration
- ICACHE_STATS_EN defined:
  - hit_cnt increments on every LOOKUP cycle with cs & hit.
  - miss_cnt increments on every LOOKUP→REFILL transition.
  - Both counters are 32-bit and wrap 0xFFFFFFFF→0, reset to 0, and are unaffected by flush.
- ICACHE_STATS_EN undefined: the counters and both ports are absent. All other behaviour is identical.

## Test plan
- Reset, then cs=1, addr=0x00001004: cache_stall_n=0, ireq=1, iaddr=0x00001000. Apply iack 3 cycles later with data_in={A0,A1,A2,A3}. Required: ireq drops and dout=A1 one cycle after the stall ends.
- Fill 0x00001000 and 0x00002000 (same index, different tags), then read 0x00001008 and 0x0000200C. Required: both hit with no ireq; dout is the correct word each time.
- With both ways full and 0x00001000 the most recent hit, read 0x00003000. Required: it evicts the 0x00002000 way; 0x00001000 still hits and 0x00002000 misses.
- Pulse flush, then re-read 0x00001000. Required: miss with ireq=1. Flush coincident with iack: the next lookup of the same address misses again.
- Assert rst while ireq=1, then send iack after reset. Required: ireq=0 immediately, dout=0, and no line is written (a subsequent read misses).
- With ICACHE_STATS_EN defined: 5 hits and 2 misses give hit_cnt=5, miss_cnt=2; flush leaves both unchanged.

Source files
------------

// File: rtl/icache_2way.sv
// Two-way set-associative instruction cache with LRU replacement and line refill handshake.
// Optional hit/miss counters are compiled in when ICACHE_STATS_EN is defined.
module icache_2way #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INDEX_WIDTH = 8,
    parameter int WORD_BITS   = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cs,
    input  logic [ADDR_WIDTH-1:0]             addr,
    input  logic                              flush,
    output logic [31:0]                       dout,
    output logic                              cache_stall_n,
    output logic [ADDR_WIDTH-1:0]             iaddr,
    output logic                              ireq,
    input  logic                              iack,
    input  logic [32*(2**WORD_BITS)-1:0]      data_in
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]                       hit_cnt,
    output logic [31:0]                       miss_cnt
`endif
);

    localparam int LINE_WORDS = 2**WORD_BITS;
    localparam int LINE_BITS  = 32*LINE_WORDS;
    localparam int TAG_WIDTH  = ADDR_WIDTH - INDEX_WIDTH - WORD_BITS - 2;
    localparam int SETS       = 2**INDEX_WIDTH;

    typedef enum logic {LOOKUP, REFILL} state_t;
    state_t state;

    logic [WORD_BITS-1:0]   word;
    logic [INDEX_WIDTH-1:0] index;
    logic [TAG_WIDTH-1:0]   tag;

    logic [SETS-1:0]        valid0, valid1, lru;
    logic [TAG_WIDTH-1:0]   tag0  [SETS];
    logic [TAG_WIDTH-1:0]   tag1  [SETS];
    logic [LINE_BITS-1:0]   line0 [SETS];
    logic [LINE_BITS-1:0]   line1 [SETS];

    logic                   hit0, hit1, hit, victim;
    logic [LINE_BITS-1:0]   hit_line;
    logic [31:0]            hit_word;
    logic                   unused_addr_bits;

    assign word  = addr[WORD_BITS+1:2];
    assign index = addr[WORD_BITS+2 +: INDEX_WIDTH];
    assign tag   = addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign unused_addr_bits = ^addr[1:0];

    assign hit0     = valid0[index] && (tag0[index] == tag);
    assign hit1     = valid1[index] && (tag1[index] == tag);
    assign hit      = cs && (hit0 || hit1);
    assign hit_line = hit1 ? line1[index] : line0[index];

    // Word 0 occupies the most significant 32 bits of a line.
    always_comb begin
        hit_word = '0;
        for (int unsigned i = 0; i < LINE_WORDS; i++) begin
            if (word == i[WORD_BITS-1:0])
                hit_word = hit_line[LINE_BITS-1-32*i -: 32];
        end
    end

    always_comb begin
        if (!valid0[index])
            victim = 1'b0;
        else if (!valid1[index])
            victim = 1'b1;
        else
            victim = lru[index];
    end

    assign ireq          = (state == REFILL);
    assign iaddr         = {addr[ADDR_WIDTH-1:WORD_BITS+2], {(WORD_BITS+2){1'b0}}};
    assign cache_stall_n = ~(((state == LOOKUP) && cs && !hit) || (state == REFILL));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= LOOKUP;
            dout   <= '0;
            valid0 <= '0;
            valid1 <= '0;
            lru    <= '0;
`ifdef ICACHE_STATS_EN
            hit_cnt  <= '0;
            miss_cnt <= '0;
`endif
        end else begin
            case (state)
                LOOKUP: begin
                    if (hit) begin
                        dout       <= hit_word;
                        lru[index] <= ~hit1;
`ifdef ICACHE_STATS_EN
                        hit_cnt    <= hit_cnt + 32'd1;
`endif
                    end else if (cs) begin
                        state    <= REFILL;
`ifdef ICACHE_STATS_EN
                        miss_cnt <= miss_cnt + 32'd1;
`endif
                    end
                end
                REFILL: begin
                    if (iack) begin
                        if (victim)
                            valid1[index] <= 1'b1;
                        else
                            valid0[index] <= 1'b1;
                        lru[index] <= ~victim;
                        state      <= LOOKUP;
                    end
                end
                default: state <= LOOKUP;
            endcase
            // Flush is placed last so it overrides a same-edge valid/lru update.
            if (flush) begin
                valid0 <= '0;
                valid1 <= '0;
                lru    <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == REFILL && iack) begin
            if (victim) begin
                tag1[index]  <= tag;
                line1[index] <= data_in;
            end else begin
                tag0[index]  <= tag;
                line0[index] <= data_in;
            end
        end
    end

endmodule

// File: tb/tb_icache_2way.sv
// Randomized self-checking bench for icache_2way against a recency-list cache model.
// Counter checks are active when ICACHE_STATS_EN is defined.
module tb_icache_2way;

    localparam int AW = 32;
    localparam int IW = 8;
    localparam int WB = 2;

    logic         clk = 1'b0;
    logic         rst, cs, flush, iack;
    logic [31:0]  addr, dout, iaddr;
    logic         stall_n, ireq;
    logic [127:0] data_in;
`ifdef ICACHE_STATS_EN
    logic [31:0]  hit_cnt, miss_cnt;
`endif

    int          total = 0;
    int          bad = 0;
    int unsigned salt;
    logic [31:0] last_dout;

    // Model: each set is a recency list of up to two tags (mru first).
    logic [19:0] m_mru [256];
    logic [19:0] m_lru [256];
    int          m_cnt [256];
    int unsigned m_hits, m_misses;

    icache_2way #(.ADDR_WIDTH(AW), .INDEX_WIDTH(IW), .WORD_BITS(WB)) dut (
        .clk(clk), .rst(rst), .cs(cs), .addr(addr), .flush(flush), .dout(dout),
        .cache_stall_n(stall_n), .iaddr(iaddr), .ireq(ireq), .iack(iack), .data_in(data_in)
`ifdef ICACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a, input int unsigned w);
        return ((a >> 4) * 32'h0100_0193) ^ (w * 32'h9E37_79B9) ^ salt;
    endfunction

    function automatic logic [127:0] mem_line(input logic [31:0] a);
        logic [127:0] l = '0;
        for (int unsigned w = 0; w < 4; w++) l = {l[95:0], mem_word(a, w)};
        return l;
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / 16) % 256);
    endfunction

    function automatic logic [19:0] tag_of(input logic [31:0] a);
        return 20'(a / 4096);
    endfunction

    function automatic bit m_has(input logic [31:0] a);
        int i = idx_of(a);
        return (m_cnt[i] >= 1 && m_mru[i] == tag_of(a)) || (m_cnt[i] == 2 && m_lru[i] == tag_of(a));
    endfunction

    task automatic m_touch(input logic [31:0] a);
        int i = idx_of(a);
        if (m_cnt[i] == 2 && m_lru[i] == tag_of(a)) begin
            m_lru[i] = m_mru[i];
            m_mru[i] = tag_of(a);
        end
    endtask

    task automatic m_fill(input logic [31:0] a);
        int i = idx_of(a);
        if (m_cnt[i] >= 1) m_lru[i] = m_mru[i];
        m_mru[i] = tag_of(a);
        if (m_cnt[i] < 2) m_cnt[i] = m_cnt[i] + 1;
    endtask

    task automatic m_clear();
        for (int i = 0; i < 256; i++) m_cnt[i] = 0;
    endtask

    // fmode: 0 plain, 1 flush on the final edge (hit edge or iack edge), 2 flush in first refill wait cycle.
    task automatic do_fetch(input logic [31:0] a, input int k, input int fmode);
        bit exp_hit;
        int unsigned w;
        @(negedge clk);
        addr = a; cs = 1'b1;
        #1;
        exp_hit = m_has(a);
        w = (a >> 2) & 3;
        total++; if (stall_n !== exp_hit) begin bad++; $display("FAIL lookup_stall addr=%h got=%b exp=%b", a, stall_n, exp_hit); end
        total++; if (iaddr !== (a & ~32'hF)) begin bad++; $display("FAIL iaddr addr=%h got=%h exp=%h", a, iaddr, a & ~32'hF); end
        if (exp_hit) begin
            total++; if (ireq !== 1'b0) begin bad++; $display("FAIL hit_ireq addr=%h got=%b exp=0", a, ireq); end
            if (fmode == 1) flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            total++; if (dout !== mem_word(a, w)) begin bad++; $display("FAIL hit_dout addr=%h got=%h exp=%h", a, dout, mem_word(a, w)); end
            last_dout = mem_word(a, w);
            m_touch(a); m_hits++;
            if (fmode == 1) m_clear();
        end else begin
            @(posedge clk);
            m_misses++;
            for (int j = 0; j < k; j++) begin
                @(negedge clk); #1;
                total++; if (ireq !== 1'b1 || stall_n !== 1'b0) begin bad++; $display("FAIL refill_wait addr=%h ireq=%b stall_n=%b exp ireq=1 stall_n=0", a, ireq, stall_n); end
                if (fmode == 2 && j == 0) begin
                    flush = 1'b1;
                    @(posedge clk); #1;
                    flush = 1'b0;
                    m_clear();
                end
            end
            @(negedge clk);
            iack = 1'b1; data_in = mem_line(a);
            if (fmode == 1) flush = 1'b1;
            #1;
            total++; if (ireq !== 1'b1 || stall_n !== 1'b0) begin bad++; $display("FAIL iack_cycle addr=%h ireq=%b stall_n=%b exp ireq=1 stall_n=0", a, ireq, stall_n); end
            @(posedge clk); #1;
            iack = 1'b0; flush = 1'b0;
            data_in = {$urandom, $urandom, $urandom, $urandom};
            if (fmode == 1) m_clear(); else m_fill(a);
            @(negedge clk); #1;
            total++; if (ireq !== 1'b0) begin bad++; $display("FAIL ireq_drop addr=%h got=%b exp=0", a, ireq); end
            if (fmode == 1) begin
                total++; if (stall_n !== 1'b0) begin bad++; $display("FAIL remiss_after_flush addr=%h stall_n=%b exp=0", a, stall_n); end
                cs = 1'b0;
            end else begin
                total++; if (stall_n !== 1'b1) begin bad++; $display("FAIL post_fill_hit addr=%h stall_n=%b exp=1", a, stall_n); end
                @(posedge clk); #1;
                total++; if (dout !== mem_word(a, w)) begin bad++; $display("FAIL fill_dout addr=%h got=%h exp=%h", a, dout, mem_word(a, w)); end
                last_dout = mem_word(a, w);
                m_touch(a); m_hits++;
            end
        end
    endtask

    task automatic flush_pulse();
        @(negedge clk);
        cs = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        m_clear();
    endtask

    task automatic do_reset();
        @(negedge clk);
        cs = 1'b0; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_clear(); m_hits = 0; m_misses = 0; last_dout = '0;
    endtask

    task automatic test_reset();
        total++; if (dout !== 32'h0) begin bad++; $display("FAIL reset_dout got=%h exp=0", dout); end
        total++; if (stall_n !== 1'b1) begin bad++; $display("FAIL reset_stall_n got=%b exp=1", stall_n); end
        total++; if (ireq !== 1'b0) begin bad++; $display("FAIL reset_ireq got=%b exp=0", ireq); end
        total++; if (iaddr !== 32'h1234_5670) begin bad++; $display("FAIL reset_iaddr got=%h exp=12345670", iaddr); end
    endtask

    task automatic test_two_ways();
        do_fetch(32'h0000_2000, 1, 0);
        do_fetch(32'h0000_1008, 0, 0);
        do_fetch(32'h0000_200C, 0, 0);
        do_fetch(32'h0000_1000, 0, 0);
        do_fetch(32'h0000_3000, 2, 0);
        do_fetch(32'h0000_1000, 0, 0);
        do_fetch(32'h0000_2000, 0, 0);
    endtask

    task automatic test_flush();
        flush_pulse();
        do_fetch(32'h0000_1000, 0, 0);
        do_fetch(32'h0000_1004, 0, 1);
        do_fetch(32'h0000_1000, 2, 1);
        do_fetch(32'h0000_1000, 0, 0);
        do_fetch(32'h0000_2004, 2, 2);
        do_fetch(32'h0000_2004, 0, 0);
    endtask

    task automatic test_idle(input int n);
        @(negedge clk);
        cs = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            total++; if (dout !== last_dout || ireq !== 1'b0 || stall_n !== 1'b1) begin
                bad++; $display("FAIL idle_hold dout=%h exp=%h ireq=%b stall_n=%b", dout, last_dout, ireq, stall_n);
            end
        end
    endtask

    task automatic test_reset_mid_refill();
        @(negedge clk);
        addr = 32'h0000_5008; cs = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        total++; if (ireq !== 1'b1) begin bad++; $display("FAIL pre_reset_ireq got=%b exp=1", ireq); end
        #1 rst = 1'b1;
        #1;
        total++; if (ireq !== 1'b0) begin bad++; $display("FAIL async_reset_ireq got=%b exp=0", ireq); end
        total++; if (dout !== 32'h0) begin bad++; $display("FAIL async_reset_dout got=%h exp=0", dout); end
        cs = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_clear(); m_hits = 0; m_misses = 0; last_dout = '0;
        iack = 1'b1; data_in = mem_line(32'h0000_5008);
        @(posedge clk); #1;
        iack = 1'b0;
        total++; if (ireq !== 1'b0) begin bad++; $display("FAIL late_iack_ireq got=%b exp=0", ireq); end
        do_fetch(32'h0000_5008, 1, 0);
    endtask

`ifdef ICACHE_STATS_EN
    task automatic test_stats();
        logic [31:0] h, m;
        do_reset();
        do_fetch(32'h0000_1000, 0, 0);
        do_fetch(32'h0000_2000, 1, 0);
        do_fetch(32'h0000_1004, 0, 0);
        do_fetch(32'h0000_2008, 0, 0);
        do_fetch(32'h0000_100C, 0, 0);
        total++; if (hit_cnt !== m_hits) begin bad++; $display("FAIL stats_hits got=%0d exp=%0d", hit_cnt, m_hits); end
        total++; if (miss_cnt !== m_misses) begin bad++; $display("FAIL stats_misses got=%0d exp=%0d", miss_cnt, m_misses); end
        h = m_hits; m = m_misses;
        flush_pulse();
        total++; if (hit_cnt !== h || miss_cnt !== m) begin bad++; $display("FAIL stats_flush hits=%0d misses=%0d exp %0d %0d", hit_cnt, miss_cnt, h, m); end
    endtask

    task automatic test_stats_final();
        total++; if (hit_cnt !== m_hits || miss_cnt !== m_misses) begin
            bad++; $display("FAIL stats_final hits=%0d misses=%0d exp %0d %0d", hit_cnt, miss_cnt, m_hits, m_misses);
        end
    endtask
`endif

    task automatic test_random(input int n);
        logic [31:0] a;
        int k, r, fmode;
        for (int i = 0; i < n; i++) begin
            a = ($urandom_range(1, 4) << 12) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2);
            k = $urandom_range(0, 3);
            r = $urandom_range(0, 19);
            fmode = (r == 0) ? 1 : ((r == 1 && k > 0) ? 2 : 0);
            do_fetch(a, k, fmode);
            if ($urandom_range(0, 9) == 0) test_idle(1);
        end
    endtask

    initial begin
        rst = 1'b1; cs = 1'b0; flush = 1'b0; iack = 1'b0;
        addr = 32'h1234_5678; data_in = '0;
        salt = $urandom;
        m_clear(); m_hits = 0; m_misses = 0; last_dout = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        test_reset();
        do_fetch(32'h0000_1004, 3, 0);
        test_two_ways();
        test_flush();
        test_idle(3);
        test_reset_mid_refill();
`ifdef ICACHE_STATS_EN
        test_stats();
`endif
        test_random(300);
`ifdef ICACHE_STATS_EN
        test_stats_final();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
